loop_filter_pi_gear: RTL and testbench

- Parametrised successor to the fixed-gain ADPLL PI loop filter.
- Pipelined proportional-integral filter that turns the signed phase-detector error into the DCO control code.
- Adds per-sample valid handshake, round-half-up, output saturation with integrator anti-windup, and acquisition→tracking gain gear-shifting.
- Sits between the phase detector and the DCO in the gen_clk_i domain.

---
 rtl/loop_filter_pi_gear_if.sv | 35 +++
 rtl/loop_filter_pi_gear.sv | 233 +++++++++++++++++++++++
 tb/tb_loop_filter_pi_gear.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/loop_filter_pi_gear_if.sv
// rtl/loop_filter_pi_gear_if.sv - error sample, gain and DCO control bundle for loop_filter_pi_gear
interface loop_filter_pi_gear_if #(
  parameter int ERROR_WIDTH  = 8,
  parameter int DCO_CC_WIDTH = 9,
  parameter int KP_WIDTH     = 4,
  parameter int KI_WIDTH     = 6
) ();

  logic                           enable_i;
  logic                           error_valid_i;
  logic signed [ERROR_WIDTH-1:0]  error_i;
  logic        [KP_WIDTH-1:0]     kp_acq_i;
  logic        [KI_WIDTH-1:0]     ki_acq_i;
  logic        [KP_WIDTH-1:0]     kp_trk_i;
  logic        [KI_WIDTH-1:0]     ki_trk_i;
  logic signed [DCO_CC_WIDTH-1:0] dco_cc_o;
  logic                           dco_cc_valid_o;
  logic                           sat_o;
  logic                           gear_o;

  // Phase detector / control side drives samples and gains
  modport master (
    output enable_i, error_valid_i, error_i,
    output kp_acq_i, ki_acq_i, kp_trk_i, ki_trk_i,
    input  dco_cc_o, dco_cc_valid_o, sat_o, gear_o
  );

  // Loop filter side
  modport slave (
    input  enable_i, error_valid_i, error_i,
    input  kp_acq_i, ki_acq_i, kp_trk_i, ki_trk_i,
    output dco_cc_o, dco_cc_valid_o, sat_o, gear_o
  );

endinterface

// File: rtl/loop_filter_pi_gear.sv
// rtl/loop_filter_pi_gear.sv - pipelined PI loop filter with rounding, saturation, anti-windup and gear shift (LOOP_FILTER_GEAR_EN)
module loop_filter_pi_gear #(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 9,
  parameter int KP_WIDTH      = 4,
  parameter int KP_FRAC_WIDTH = 2,
  parameter int KI_WIDTH      = 6,
  parameter int KI_FRAC_WIDTH = 5,
  parameter int ACC_WIDTH     = 18,
  parameter int GEAR_CYCLES   = 64
) (
  input logic                  gen_clk_i,
  input logic                  reset_i,
  loop_filter_pi_gear_if.slave bus
);

  // Product widths: signed error times zero-extended unsigned gain
  localparam int P_W   = ERROR_WIDTH + KP_WIDTH + 1;
  localparam int I_W   = ERROR_WIDTH + KI_WIDTH + 1;
  // Proportional term is brought onto the integrator's binary point
  localparam int ALIGN = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
  localparam int PA_W  = P_W + ALIGN;
  // Two guard bits: one for the p+acc add, one for the rounding add
  localparam int S_W   = ((PA_W > ACC_WIDTH) ? PA_W : ACC_WIDTH) + 2;

  localparam logic [S_W-1:0] RND = S_W'(1) << (KI_FRAC_WIDTH - 1);

  localparam logic [ACC_WIDTH-1:0]    ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]    ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [DCO_CC_WIDTH-1:0] CC_MAX  = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
  localparam logic [DCO_CC_WIDTH-1:0] CC_MIN  = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

  logic                accept;
  logic                gear;
  logic [KP_WIDTH-1:0] kp_sel;
  logic [KI_WIDTH-1:0] ki_sel;

  // Input capture stage
  logic                   in_valid_d, in_valid_q;
  logic [ERROR_WIDTH-1:0] err_d, err_q;
  logic [KP_WIDTH-1:0]    kp_d, kp_q;
  logic [KI_WIDTH-1:0]    ki_d, ki_q;

  // Product stage
  logic                  s1_valid_d, s1_valid_q;
  logic signed [P_W-1:0] p_d, p_q;
  logic signed [I_W-1:0] i_d, i_q;
  logic signed [P_W-1:0] err_p, kp_p;
  logic signed [I_W-1:0] err_i, ki_i;

  // Integrate / sum / round / clip stage
  logic signed [ACC_WIDTH-1:0]    acc_d, acc_q;
  logic signed [DCO_CC_WIDTH-1:0] dco_cc_d, dco_cc_q;
  logic                           dco_cc_valid_d, dco_cc_valid_q;
  logic                           sat_d, sat_q;
  logic                           sat_neg_d, sat_neg_q;

  logic signed [ACC_WIDTH:0]      acc_ext, i_ext, acc_sum;
  logic signed [ACC_WIDTH-1:0]    acc_sat, acc_upd;
  logic                           windup_hold;
  logic signed [S_W-1:0]          p_al, acc_al, sum_rnd, shr;
  logic [S_W-DCO_CC_WIDTH:0]      hi;
  logic                           clip;

  // Sample qualifier and gain-set selection for the current gear
  always_comb begin
    accept = bus.error_valid_i & bus.enable_i;
`ifdef LOOP_FILTER_GEAR_EN
    kp_sel = gear ? bus.kp_trk_i : bus.kp_acq_i;
    ki_sel = gear ? bus.ki_trk_i : bus.ki_acq_i;
`else
    kp_sel = bus.kp_acq_i;
    ki_sel = bus.ki_acq_i;
`endif
  end

  // Capture the accepted sample together with the gains in force at accept
  always_comb begin
    in_valid_d = accept;
    err_d      = err_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    if (accept) begin
      err_d = bus.error_i;
      kp_d  = kp_sel;
      ki_d  = ki_sel;
    end
  end

  // Signed x unsigned products, gains zero-extended so they stay positive
  always_comb begin
    err_p      = {{(P_W-ERROR_WIDTH){err_q[ERROR_WIDTH-1]}}, err_q};
    kp_p       = {{(P_W-KP_WIDTH){1'b0}}, kp_q};
    err_i      = {{(I_W-ERROR_WIDTH){err_q[ERROR_WIDTH-1]}}, err_q};
    ki_i       = {{(I_W-KI_WIDTH){1'b0}}, ki_q};
    p_d        = err_p * kp_p;
    i_d        = err_i * ki_i;
    s1_valid_d = in_valid_q;
  end

  // Integrator with anti-windup, aligned sum, round-half-up and output clip
  always_comb begin
    acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
    i_ext   = {{(ACC_WIDTH+1-I_W){i_q[I_W-1]}}, i_q};
    acc_sum = acc_ext + i_ext;
    if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1]) begin
      acc_sat = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sat = acc_sum[ACC_WIDTH-1:0];
    end

    // Freeze only while pushing further into the rail we last clipped on;
    // an opposite-sign step is taken at once so recovery has no delay.
    windup_hold = sat_q & (|i_q) & (i_q[I_W-1] == sat_neg_q);
    acc_upd     = windup_hold ? acc_q : acc_sat;

    p_al    = {{(S_W-P_W){p_q[P_W-1]}}, p_q} <<< ALIGN;
    acc_al  = {{(S_W-ACC_WIDTH){acc_upd[ACC_WIDTH-1]}}, acc_upd};
    sum_rnd = p_al + acc_al + $signed(RND);
    shr     = sum_rnd >>> KI_FRAC_WIDTH;

    // Fits the output only if all bits above its sign bit equal the sign
    hi   = shr[S_W-1:DCO_CC_WIDTH-1];
    clip = ~((&hi) | ~(|hi));

    acc_d          = acc_q;
    dco_cc_d       = dco_cc_q;
    sat_d          = sat_q;
    sat_neg_d      = sat_neg_q;
    dco_cc_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      acc_d = acc_upd;
      if (clip) begin
        dco_cc_d  = shr[S_W-1] ? CC_MIN : CC_MAX;
        sat_d     = 1'b1;
        sat_neg_d = shr[S_W-1];
      end else begin
        dco_cc_d  = shr[DCO_CC_WIDTH-1:0];
        sat_d     = 1'b0;
        sat_neg_d = 1'b0;
      end
    end
  end

  // Datapath and pipeline-valid registers
  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_valid_q     <= 1'b0;
      err_q          <= '0;
      kp_q           <= '0;
      ki_q           <= '0;
      s1_valid_q     <= 1'b0;
      p_q            <= '0;
      i_q            <= '0;
      acc_q          <= '0;
      dco_cc_q       <= '0;
      dco_cc_valid_q <= 1'b0;
      sat_q          <= 1'b0;
      sat_neg_q      <= 1'b0;
    end else begin
      in_valid_q     <= in_valid_d;
      err_q          <= err_d;
      kp_q           <= kp_d;
      ki_q           <= ki_d;
      s1_valid_q     <= s1_valid_d;
      p_q            <= p_d;
      i_q            <= i_d;
      acc_q          <= acc_d;
      dco_cc_q       <= dco_cc_d;
      dco_cc_valid_q <= dco_cc_valid_d;
      sat_q          <= sat_d;
      sat_neg_q      <= sat_neg_d;
    end
  end

`ifdef LOOP_FILTER_GEAR_EN
  typedef enum logic {ST_ACQ = 1'b0, ST_TRK = 1'b1} gear_state_e;

  localparam int             CNT_W    = $clog2(GEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GEAR_CYCLES - 1);

  gear_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gear_q;

  // Acquisition -> tracking after GEAR_CYCLES accepted samples; disable restarts
  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_ACQ;
      cnt_q   <= '0;
      gear_q  <= 1'b0;
    end else if (!bus.enable_i) begin
      state_q <= ST_ACQ;
      cnt_q   <= '0;
      gear_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACQ: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_TRK;
              gear_q  <= 1'b1;
            end
          end
        end
        ST_TRK: begin
          gear_q <= 1'b1;
        end
        default: begin
          state_q <= ST_ACQ;
          gear_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gear = gear_q;
`else
  localparam int unused_gear_cycles = GEAR_CYCLES;

  logic unused_trk_gains;

  assign gear             = 1'b0;
  assign unused_trk_gains = ^{bus.kp_trk_i, bus.ki_trk_i};
`endif

  assign bus.dco_cc_o       = dco_cc_q;
  assign bus.dco_cc_valid_o = dco_cc_valid_q;
  assign bus.sat_o          = sat_q;
  assign bus.gear_o         = gear;

endmodule

// File: tb/tb_loop_filter_pi_gear.sv
// tb/tb_loop_filter_pi_gear.sv - directed self-checking bench for loop_filter_pi_gear
module tb_loop_filter_pi_gear;

  localparam int EW  = 8;
  localparam int CW  = 9;
  localparam int KPW = 4;
  localparam int KIW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef LOOP_FILTER_GEAR_EN
  bit gear_en = 1'b1;
`else
  bit gear_en = 1'b0;
`endif

  always #5 clk = ~clk;

  loop_filter_pi_gear_if #(
    .ERROR_WIDTH(EW), .DCO_CC_WIDTH(CW), .KP_WIDTH(KPW), .KI_WIDTH(KIW)
  ) bus ();

  loop_filter_pi_gear #(
    .ERROR_WIDTH(EW), .DCO_CC_WIDTH(CW), .KP_WIDTH(KPW), .KP_FRAC_WIDTH(2),
    .KI_WIDTH(KIW), .KI_FRAC_WIDTH(5), .ACC_WIDTH(18), .GEAR_CYCLES(4)
  ) dut (
    .gen_clk_i(clk),
    .reset_i  (rst),
    .bus      (bus.slave)
  );

  // Present one cycle of inputs, then sample 1 time unit after the edge
  task automatic tick(input logic en, input logic vld, input int err);
    bus.enable_i      = en;
    bus.error_valid_i = vld;
    bus.error_i       = EW'(err);
    @(posedge clk);
    #1;
  endtask

  task automatic set_gains(input int kpa, input int kia, input int kpt, input int kit);
    bus.kp_acq_i = KPW'(kpa);
    bus.ki_acq_i = KIW'(kia);
    bus.kp_trk_i = KPW'(kpt);
    bus.ki_trk_i = KIW'(kit);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_gains(4, 0, 4, 0);
    tick(1'b1, 1'b1, 5);
    tick(1'b1, 1'b1, 5);
    total++; if (bus.dco_cc_o !== 9'sd0) begin bad++; $display("FAIL rst_cc got %0d want 0", bus.dco_cc_o); end
    total++; if (bus.dco_cc_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", bus.dco_cc_valid_o); end
    total++; if (bus.sat_o !== 1'b0) begin bad++; $display("FAIL rst_sat got %b want 0", bus.sat_o); end
    total++; if (bus.gear_o !== 1'b0) begin bad++; $display("FAIL rst_gear got %b want 0", bus.gear_o); end
    rst = 1'b0;
    tick(1'b1, 1'b1, 20);
    tick(1'b1, 1'b1, 21);
    tick(1'b1, 1'b1, 22);
    total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== 9'sd20) begin
      bad++; $display("FAIL pre_rst_out got v=%b cc=%0d want v=1 cc=20", bus.dco_cc_valid_o, bus.dco_cc_o);
    end
    // Asynchronous assertion between edges
    #2 rst = 1'b1;
    #1;
    total++; if (bus.dco_cc_o !== 9'sd0) begin bad++; $display("FAIL async_rst_cc got %0d want 0", bus.dco_cc_o); end
    total++; if (bus.dco_cc_valid_o !== 1'b0) begin bad++; $display("FAIL async_rst_valid got %b want 0", bus.dco_cc_valid_o); end
    total++; if (bus.sat_o !== 1'b0) begin bad++; $display("FAIL async_rst_sat got %b want 0", bus.sat_o); end
    total++; if (bus.gear_o !== 1'b0) begin bad++; $display("FAIL async_rst_gear got %b want 0", bus.gear_o); end
    tick(1'b0, 1'b0, 0);
    rst = 1'b0;
    tick(1'b1, 1'b1, -5);
    total++; if (bus.dco_cc_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_flush0 got %b want 0", bus.dco_cc_valid_o); end
    tick(1'b0, 1'b0, 0);
    total++; if (bus.dco_cc_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_flush1 got %b want 0", bus.dco_cc_valid_o); end
    tick(1'b0, 1'b0, 0);
    total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== -9'sd5) begin
      bad++; $display("FAIL post_rst_first got v=%b cc=%0d want v=1 cc=-5", bus.dco_cc_valid_o, bus.dco_cc_o);
    end
    tick(1'b0, 1'b0, 0);
    total++; if (bus.dco_cc_valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_single got %b want 0", bus.dco_cc_valid_o); end
  endtask

  task automatic test_proportional;
    do_reset();
    set_gains(4, 0, 7, 63);
    tick(1'b1, 1'b1, 10);
    tick(1'b0, 1'b0, 0);
    total++; if (bus.dco_cc_valid_o !== 1'b0) begin bad++; $display("FAIL prop_n1 got %b want 0", bus.dco_cc_valid_o); end
    tick(1'b0, 1'b0, 0);
    total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== 9'sd10 || bus.sat_o !== 1'b0) begin
      bad++; $display("FAIL prop_pos got v=%b cc=%0d sat=%b want v=1 cc=10 sat=0", bus.dco_cc_valid_o, bus.dco_cc_o, bus.sat_o);
    end
    tick(1'b1, 1'b1, -3);
    total++; if (bus.dco_cc_valid_o !== 1'b0 || bus.dco_cc_o !== 9'sd10) begin
      bad++; $display("FAIL prop_hold got v=%b cc=%0d want v=0 cc=10", bus.dco_cc_valid_o, bus.dco_cc_o);
    end
    tick(1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 0);
    total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== -9'sd3) begin
      bad++; $display("FAIL prop_neg got v=%b cc=%0d want v=1 cc=-3", bus.dco_cc_valid_o, bus.dco_cc_o);
    end
  endtask

  // ki=0.25, error=+1: acc 8,16,24,32 (x1/32) -> 0,1,1,1; disabled samples leave acc alone
  task automatic test_integral;
    int want_cc[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    bit want_v[10]  = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    do_reset();
    set_gains(0, 8, 0, 8);
    for (int c = 0; c < 10; c++) begin
      tick(!(c >= 4 && c <= 6), (c <= 7), 1);
      total++; if (bus.dco_cc_valid_o !== want_v[c]) begin
        bad++; $display("FAIL int_valid c=%0d got %b want %b", c, bus.dco_cc_valid_o, want_v[c]);
      end
      total++; if (bus.dco_cc_o !== CW'(want_cc[c]) || bus.sat_o !== 1'b0) begin
        bad++; $display("FAIL int_cc c=%0d got cc=%0d sat=%b want cc=%0d sat=0", c, bus.dco_cc_o, bus.sat_o, want_cc[c]);
      end
    end
  endtask

  task automatic test_saturation;
    int err_p[6]  = '{127, 127, 127, 127, -1, -8};
    int kp_p[6]   = '{12, 12, 12, 12, 0, 0};
    int want_p[6] = '{255, 255, 255, 255, 16, 15};
    bit sat_p[6]  = '{1, 1, 1, 1, 0, 0};
    int err_n[4]  = '{-128, -128, -128, 127};
    int want_n[4] = '{-252, -256, -256, -254};
    bit sat_n[4]  = '{0, 1, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        set_gains(kp_p[c], 4, kp_p[c], 4);
        tick(1'b1, 1'b1, err_p[c]);
      end else begin
        tick(1'b1, 1'b0, 0);
      end
      if (c >= 2) begin
        total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== CW'(want_p[c-2]) || bus.sat_o !== sat_p[c-2]) begin
          bad++; $display("FAIL sat_pos s=%0d got v=%b cc=%0d sat=%b want v=1 cc=%0d sat=%b",
                          c - 2, bus.dco_cc_valid_o, bus.dco_cc_o, bus.sat_o, want_p[c-2], sat_p[c-2]);
        end
      end
    end
    do_reset();
    set_gains(0, 63, 0, 63);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) tick(1'b1, 1'b1, err_n[c]);
      else       tick(1'b1, 1'b0, 0);
      if (c >= 2) begin
        total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== CW'(want_n[c-2]) || bus.sat_o !== sat_n[c-2]) begin
          bad++; $display("FAIL sat_neg s=%0d got v=%b cc=%0d sat=%b want v=1 cc=%0d sat=%b",
                          c - 2, bus.dco_cc_valid_o, bus.dco_cc_o, bus.sat_o, want_n[c-2], sat_n[c-2]);
        end
      end
    end
  endtask

  // acq kp=1.0 -> 8, trk kp=0.5 -> 4 for error=+8
  task automatic test_gear;
    int want;
    do_reset();
    set_gains(4, 0, 2, 0);
    for (int c = 0; c < 7; c++) begin
      tick(1'b1, (c <= 4), 8);
      total++; if (bus.gear_o !== (gear_en && c >= 3)) begin
        bad++; $display("FAIL gear_state c=%0d got %b want %b", c, bus.gear_o, (gear_en && c >= 3));
      end
      if (c >= 2) begin
        want = (gear_en && c == 6) ? 4 : 8;
        total++; if (bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== CW'(want)) begin
          bad++; $display("FAIL gear_out c=%0d got v=%b cc=%0d want v=1 cc=%0d", c, bus.dco_cc_valid_o, bus.dco_cc_o, want);
        end
      end
    end
    tick(1'b0, 1'b1, 8);
    total++; if (bus.gear_o !== 1'b0 || bus.dco_cc_valid_o !== 1'b0) begin
      bad++; $display("FAIL gear_disable got gear=%b v=%b want gear=0 v=0", bus.gear_o, bus.dco_cc_valid_o);
    end
    tick(1'b1, 1'b1, 8);
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b0, 0);
    total++; if (bus.gear_o !== 1'b0 || bus.dco_cc_valid_o !== 1'b1 || bus.dco_cc_o !== 9'sd8) begin
      bad++; $display("FAIL gear_restart got gear=%b v=%b cc=%0d want gear=0 v=1 cc=8", bus.gear_o, bus.dco_cc_valid_o, bus.dco_cc_o);
    end
  endtask

  // kp=1.0, ki=0 so each accepted error reappears unchanged two edges later
  task automatic test_back_to_back;
    bit en_a[16]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    bit vld_a[16] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    int err_a[16] = '{1, -2, 3, -4, 5, 0, 6, 0, -7, 50, 51, 0, 9, 0, 0, 0};
    bit exp_v;
    int last;
    int pulses;
    do_reset();
    set_gains(4, 0, 4, 0);
    last   = 0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      tick(en_a[c], vld_a[c], err_a[c]);
      exp_v = (c >= 2) ? (en_a[c-2] & vld_a[c-2]) : 1'b0;
      if (exp_v) last = err_a[c-2];
      if (bus.dco_cc_valid_o === 1'b1) pulses++;
      total++; if (bus.dco_cc_valid_o !== exp_v || bus.dco_cc_o !== CW'(last)) begin
        bad++; $display("FAIL b2b c=%0d got v=%b cc=%0d want v=%b cc=%0d", c, bus.dco_cc_valid_o, bus.dco_cc_o, exp_v, last);
      end
    end
    total++; if (pulses != 8) begin bad++; $display("FAIL b2b_pulses got %0d want 8", pulses); end
  endtask

  initial begin
    bus.enable_i      = 1'b0;
    bus.error_valid_i = 1'b0;
    bus.error_i       = '0;
    set_gains(0, 0, 0, 0);
    test_reset();
    test_proportional();
    test_integral();
    test_saturation();
    test_gear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
